lbdr_input_fifo: RTL and testbench
==================================

# lbdr_input_fifo

Per-input-port flit buffer that sits directly upstream of the LBDR routing stage. It accepts flits from the neighbouring router's output link and stores them in a first-word-fall-through queue. It presents the head flit's `flit_id` and `dst_addr` fields, plus `empty`, to the LBDR stage, and returns one credit upstream for every flit consumed. An optional protocol checker flags overflow, underflow and malformed packet sequences.

## Interface

Parameters:
- `DATA_WIDTH`, 32, flit width in bits; minimum 11.
- `DEPTH`, 4, number of flit slots; power of 2, minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  upstream presents a flit on `data_in` this cycle.
- `data_in`  in  DATA_WIDTH  incoming flit.
- `read_en`  in  1  downstream pops the head flit this cycle.
- `data_out`  out  DATA_WIDTH  head flit; valid only while `empty`=0.
- `flit_id`  out  3  `data_out[DATA_WIDTH-1:DATA_WIDTH-3]`.
- `dst_addr`  out  4  `data_out[DATA_WIDTH-4:DATA_WIDTH-7]`; meaningful only for HEADER flits.
- `empty`  out  1  queue holds no flits.
- `full`  out  1  queue holds DEPTH flits.
- `credit_out`  out  1  one-cycle pulse per flit popped; returned upstream.
- `err`  out  3  sticky error flags {seq, underflow, overflow}; zero when the checker is compiled out.

## Operation

- Storage is a DEPTH-entry register array. Write and read pointers are log2(DEPTH)+1 bits wide; the MSB is a wrap bit.
  - `empty` = (wr_ptr == rd_ptr).
  - `full` = pointers equal in their low bits and different in the MSB.
- **Write accept.** A write is accepted when `valid_in`=1 and (`full`=0 or `read_en`=1). It stores `data_in` at wr_ptr and increments wr_ptr.
- **Read accept.** A read is accepted when `read_en`=1 and `empty`=0. It increments rd_ptr.
- **Simultaneous write and read:**
  - When full, both are accepted; occupancy stays at DEPTH.
  - When empty, only the write is accepted; the read is ignored.
- Pointers wrap naturally modulo 2·DEPTH.
- **Head presentation.** `data_out`, `flit_id` and `dst_addr` are driven combinationally from mem[rd_ptr]. This is first-word fall-through: there is no read latency.
- **Credit return.** `credit_out` is registered; it is 1 in the cycle after each accepted read.
- **Flit encodings** (shared package): HEADER=3'b001, BODY=3'b010, TAIL=3'b100.
  - A single-flit packet is encoded as HEADER|TAIL = 3'b101.

## Timing

- **Reset values:**
  - `empty`=1, `full`=0, `credit_out`=0, `err`=0.
  - Both pointers = 0.
  - Memory contents are not reset; `data_out` is undefined while empty.
- **Reset mid-operation.** Asserting `rst` discards all stored flits immediately, without waiting for a clock edge. No credits are issued for discarded flits; upstream re-initialises its credit count from its own reset.
- **Write latency.** A flit written at edge N is visible on `data_out`, with `empty`=0, after edge N.
- **Read effect.** A read at edge N advances `data_out` to the next flit (or sets `empty`) after edge N. `credit_out` is high for the cycle following edge N.
- **Full flag.** `full` rises after the edge that accepts the DEPTH-th outstanding flit. It falls after the next accepted read that has no accompanying write.
- **Flow control.** Upstream never writes with `full`=1 and `read_en`=0; such a write is dropped.

## Configuration

- Macro: `LBDR_FIFO_CHECK_EN`.
- **Defined:** the checker is instantiated and its flags are sticky until `rst`.
  - overflow (`err[0]`): set on a dropped write.
  - underflow (`err[1]`): set when `read_en`=1 while `empty`=1.
  - seq (`err[2]`): set when an accepted write breaks packet order. The checker tracks an in-packet state bit:
    - BODY or TAIL while idle;
    - HEADER while in a packet;
    - any other encoding.
  - Flags update one cycle after the offending edge.
- **Undefined:** no checker logic is built and `err` is tied to 3'b000.

## Structure

- Shared package: HEADER/BODY/TAIL encodings, the flit field offsets, and the `err` bit indices.
- Sub-module `lbdr_fifo_checker`, instantiated under `LBDR_FIFO_CHECK_EN`.
  - Inputs: `valid_in`, write-accept, `read_en`, `empty`, and the incoming `flit_id`.
  - Output: `err`.

## Test plan

- **Reset.** Assert `rst` asynchronously mid-cycle with 2 flits stored: outputs are `empty`=1, `full`=0, `credit_out`=0, `err`=0, and they change before the next clock edge.
- **Fill and drain.** Write 4 flits with dst_addr 0x5, 0xA, 0x3, 0xF.
  - `full`=1 after the 4th write.
  - Pop 4 times: `dst_addr` reads 0x5, 0xA, 0x3, 0xF in order.
  - 4 `credit_out` pulses, each one cycle after its pop.
  - `empty`=1 at the end.
- **Full with simultaneous read and write.** With 4 flits stored, apply `valid_in`=1 and `read_en`=1 at the same edge: occupancy stays 4, `full` stays 1, the new flit emerges 4 pops later, and no overflow flag is set.
- **Empty with simultaneous read and write.** With the queue empty, apply `valid_in`=1 and `read_en`=1: the write is accepted, `empty`=0 next cycle, no `credit_out` pulse, and `err[1]` is set when the checker is enabled.
- **Pointer wrap.** Stream 10 flits, keeping occupancy at ≤2: data order is preserved across the pointer wrap, and 10 credits are returned.
- **Checker.** Apply BODY, HEADER, HEADER, then a write while full: `err` = 3'b101, and it stays at that value until `rst`.

Source files
------------

// File: rtl/lbdr_input_fifo_pkg.sv
// lbdr_input_fifo_pkg: flit encodings, field widths and err bit indices shared by the input FIFO
package lbdr_input_fifo_pkg;
    typedef enum logic [2:0] {
        FLIT_HEADER = 3'b001,
        FLIT_BODY   = 3'b010,
        FLIT_TAIL   = 3'b100,
        FLIT_SINGLE = 3'b101
    } flit_t;
    localparam int ID_W    = 3;
    localparam int DST_W   = 4;
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    localparam int ERR_SEQ = 2;
endpackage

// File: rtl/lbdr_fifo_checker.sv
// lbdr_fifo_checker: sticky overflow/underflow/packet-sequence flags for the LBDR input FIFO
module lbdr_fifo_checker
    import lbdr_input_fifo_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            wr_accept,
    input  logic            read_en,
    input  logic            empty,
    input  logic [ID_W-1:0] flit_id,
    output logic [2:0]      err
);
    logic       in_pkt;
    logic       in_pkt_nxt;
    logic       bad_seq;
    logic [2:0] set;
    // classify the incoming flit against the in-packet state and flag this cycle's violations
    always_comb begin
        bad_seq = (flit_id == FLIT_BODY || flit_id == FLIT_TAIL) ? !in_pkt :
                  (flit_id == FLIT_HEADER || flit_id == FLIT_SINGLE) ? in_pkt : 1'b1;
        in_pkt_nxt = !wr_accept ? in_pkt :
                     (flit_id == FLIT_HEADER) ? 1'b1 :
                     (flit_id == FLIT_TAIL || flit_id == FLIT_SINGLE) ? 1'b0 : in_pkt;
        set = '0;
        set[ERR_OVF] = valid_in && !wr_accept;
        set[ERR_UDF] = read_en && empty;
        set[ERR_SEQ] = wr_accept && bad_seq;
    end
    // flags accumulate until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err    <= '0;
            in_pkt <= 1'b0;
        end else begin
            err    <= err | set;
            in_pkt <= in_pkt_nxt;
        end
    end
endmodule

// File: rtl/lbdr_input_fifo.sv
// lbdr_input_fifo: FWFT flit queue feeding LBDR, with credit return; checker built under LBDR_FIFO_CHECK_EN
module lbdr_input_fifo
    import lbdr_input_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ID_W-1:0]       flit_id,
    output logic [DST_W-1:0]      dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic                  credit_out,
    output logic [2:0]            err
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_accept = read_en && !empty;
    assign wr_accept = valid_in && (!full || read_en);
    assign data_out  = mem[rd_ptr[AW-1:0]];
    assign flit_id   = data_out[DATA_WIDTH-1 -: ID_W];
    assign dst_addr  = data_out[DATA_WIDTH-1-ID_W -: DST_W];
    // flit storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[AW-1:0]] <= data_in;
    end
    // pointers and credit pulse; reset drops all stored flits at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            credit_out <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + (AW+1)'(wr_accept);
            rd_ptr     <= rd_ptr + (AW+1)'(rd_accept);
            credit_out <= rd_accept;
        end
    end
`ifdef LBDR_FIFO_CHECK_EN
    lbdr_fifo_checker u_checker (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .wr_accept (wr_accept),
        .read_en   (read_en),
        .empty     (empty),
        .flit_id   (data_in[DATA_WIDTH-1 -: ID_W]),
        .err       (err)
    );
`else
    assign err = 3'b000;
`endif
endmodule

// File: tb/tb_lbdr_input_fifo.sv
// tb_lbdr_input_fifo: queue-model self-checking bench for lbdr_input_fifo
module tb_lbdr_input_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0;
    logic read_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [2:0] flit_id;
    logic [3:0] dst_addr;
    logic empty, full, credit_out;
    logic [2:0] err;
    int n_tests = 0;
    int n_fail = 0;
    int credits = 0;
    logic [DW-1:0] m_q[$];
    logic m_credit = 1'b0;
    logic [2:0] m_err = 3'b000;
    logic m_in_pkt = 1'b0;

    lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .read_en(read_en),
        .data_out(data_out), .flit_id(flit_id), .dst_addr(dst_addr), .empty(empty),
        .full(full), .credit_out(credit_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [3:0] dst);
        return {id, dst, 25'($urandom)};
    endfunction

    // reference: an ordered queue of flits plus packet-rule bookkeeping
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_credit = 1'b0;
            m_err = 3'b000;
            m_in_pkt = 1'b0;
        end else begin
            int n;
            logic rd, wr, bad;
            logic [2:0] id;
            n = m_q.size();
            rd = read_en && n > 0;
            wr = valid_in && (n < DEPTH || read_en);
            id = data_in[DW-1:DW-3];
            if (valid_in && !wr) m_err[0] = 1'b1;
            if (read_en && n == 0) m_err[1] = 1'b1;
            if (wr) begin
                bad = 1'b0;
                case (id)
                    3'b001: begin bad = m_in_pkt; m_in_pkt = 1'b1; end
                    3'b010: bad = !m_in_pkt;
                    3'b100: begin bad = !m_in_pkt; m_in_pkt = 1'b0; end
                    3'b101: begin bad = m_in_pkt; m_in_pkt = 1'b0; end
                    default: bad = 1'b1;
                endcase
                if (bad) m_err[2] = 1'b1;
            end
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(data_in);
            m_credit = rd;
        end
    end

    // every-cycle comparison against the reference, away from the rising edge
    always @(negedge clk) begin
        if (!rst) begin
            check("empty", 32'(empty), 32'(m_q.size() == 0));
            check("full", 32'(full), 32'(m_q.size() == DEPTH));
            check("credit_out", 32'(credit_out), 32'(m_credit));
`ifdef LBDR_FIFO_CHECK_EN
            check("err", 32'(err), 32'(m_err));
`else
            check("err", 32'(err), 32'd0);
`endif
            if (m_q.size() > 0) begin
                check("data_out", data_out, m_q[0]);
                check("flit_id", 32'(flit_id), 32'(m_q[0][DW-1:DW-3]));
                check("dst_addr", 32'(dst_addr), 32'(m_q[0][DW-4:DW-7]));
            end
            if (credit_out) credits++;
        end
    end

    task automatic cyc(input logic v, input logic r, input logic [DW-1:0] d);
        valid_in = v;
        read_en = r;
        data_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        read_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [3:0] dsts[4];
        logic [DW-1:0] marker;
        int c0;
        dsts[0] = 4'h5; dsts[1] = 4'hA; dsts[2] = 4'h3; dsts[3] = 4'hF;
        do_reset();
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // fill and drain
        c0 = credits;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, mk(3'b101, dsts[i]));
        check("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_dst", 32'(dst_addr), 32'(dsts[i]));
            cyc(1'b0, 1'b1, '0);
            check("drain_credit", 32'(credit_out), 32'd1);
        end
        cyc(1'b0, 1'b0, '0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_credits", 32'(credits - c0), 32'd4);

        // full with simultaneous read and write
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, mk(3'b101, 4'(i)));
        marker = mk(3'b101, 4'h9);
        cyc(1'b1, 1'b1, marker);
        check("full_rw_full", 32'(full), 32'd1);
        check("full_rw_ovf", 32'(err[0]), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
        check("full_rw_marker", data_out, marker);
        cyc(1'b0, 1'b1, '0);
        check("full_rw_drained", 32'(empty), 32'd1);

        // empty with simultaneous read and write
        cyc(1'b1, 1'b1, mk(3'b101, 4'h7));
        check("empty_rw_empty", 32'(empty), 32'd0);
        check("empty_rw_credit", 32'(credit_out), 32'd0);
`ifdef LBDR_FIFO_CHECK_EN
        check("empty_rw_udf", 32'(err[1]), 32'd1);
`endif

        // asynchronous reset with two flits stored
        cyc(1'b1, 1'b0, mk(3'b101, 4'h1));
        valid_in = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_empty", 32'(empty), 32'd1);
        check("async_full", 32'(full), 32'd0);
        check("async_credit", 32'(credit_out), 32'd0);
        check("async_err", 32'(err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // pointer wrap with occupancy kept at most 2
        c0 = credits;
        for (int i = 0; i < 10; i++) cyc(1'b1, i > 0, mk(3'b101, 4'(i)));
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
        check("wrap_credits", 32'(credits - c0), 32'd10);
        check("wrap_empty", 32'(empty), 32'd1);

        // randomized traffic, mostly legal packet sequences
        for (int i = 0; i < 400; i++) begin
            logic [2:0] id;
            case ($urandom_range(0, 9))
                0: id = 3'($urandom);
                1, 2: id = 3'b001;
                3, 4, 5: id = 3'b010;
                6, 7: id = 3'b100;
                default: id = 3'b101;
            endcase
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, mk(id, 4'($urandom)));
        end

        // checker scenario
        do_reset();
        cyc(1'b1, 1'b0, mk(3'b010, 4'h0));
        cyc(1'b1, 1'b0, mk(3'b001, 4'h1));
        cyc(1'b1, 1'b0, mk(3'b001, 4'h2));
        cyc(1'b1, 1'b0, mk(3'b010, 4'h3));
        cyc(1'b1, 1'b0, mk(3'b100, 4'h4));
        cyc(1'b0, 1'b0, '0);
`ifdef LBDR_FIFO_CHECK_EN
        check("chk_err", 32'(err), 32'h5);
        repeat (3) cyc(1'b0, 1'b0, '0);
        check("chk_sticky", 32'(err), 32'h5);
`else
        check("chk_err", 32'(err), 32'h0);
`endif
        do_reset();
        check("chk_cleared", 32'(err), 32'd0);
        cyc(1'b0, 1'b0, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
